// File: rtl/core_pkg.sv
// Shared core types and constants used by the fetch path.
package core_pkg;

    localparam int FETCH_ADDRESS_BITS = 16;
    localparam int INSTR_BYTES        = 4;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [FETCH_ADDRESS_BITS-1:0] pc;
        logic [31:0]                   data;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage, head read, count output and flush.
// Flush takes priority over push and pop issued in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [WIDTH-1:0]       head_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_i);
        count_d  = count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data-only; validity is tracked entirely by count_q.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetch buffer: credit-limited sequential fetch, redirect flush
// with stale-response discard. Optional same-cycle bypass: PREFETCH_BYPASS_EN.
module fetch_prefetch
    import core_pkg::*;
#(
    parameter int                      ADDRESS_BITS = 16,
    parameter int                      DEPTH        = 4,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_BITS-1:0] redirect_pc,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [ADDRESS_BITS-1:0] imem_req_addr,
    input  logic                    imem_rsp_valid,
    input  logic [31:0]             imem_rsp_data,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [ADDRESS_BITS-1:0] inst_pc,
    output logic [31:0]             inst_data
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDRESS_BITS + 32;
    localparam logic [ADDRESS_BITS-1:0] STEP = ADDRESS_BITS'(INSTR_BYTES);

    logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_BITS-1:0] rsp_pc_q, rsp_pc_d;
    logic [ADDRESS_BITS-1:0] redirect_base;
    logic [CW-1:0]           outstanding_q, outstanding_d;
    logic [CW-1:0]           discard_q, discard_d;
    logic [CW-1:0]           fifo_count;
    logic [EW-1:0]           fifo_head;
    logic                    credit_ok, accept, rsp_ok, rsp_keep, byp;
    logic                    fifo_push, fifo_pop, fifo_empty;

    // Credit covers buffered plus in-flight so every response has a slot.
    assign credit_ok      = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH);
    assign imem_req_valid = !reset && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_ok         = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_keep       = rsp_ok && (discard_q == '0);
    assign redirect_base  = {redirect_pc[ADDRESS_BITS-1:2], 2'b00};
    assign fifo_empty     = (fifo_count == '0);

`ifdef PREFETCH_BYPASS_EN
    assign byp = rsp_keep && fifo_empty && inst_ready && !redirect_valid && !reset;
`else
    assign byp = 1'b0;
`endif

    assign fifo_push  = rsp_keep && !byp && !redirect_valid;
    assign fifo_pop   = !fifo_empty && inst_ready && !redirect_valid;
    assign inst_valid = !fifo_empty || byp;

    always_comb begin
        inst_pc   = '0;
        inst_data = '0;
        if (!fifo_empty) begin
            inst_pc   = fifo_head[EW-1:32];
            inst_data = fifo_head[31:0];
        end
`ifdef PREFETCH_BYPASS_EN
        if (byp) begin
            inst_pc   = rsp_pc_q;
            inst_data = imem_rsp_data;
        end
`endif
    end

    always_comb begin
        fetch_pc_d    = accept ? fetch_pc_q + STEP : fetch_pc_q;
        rsp_pc_d      = rsp_keep ? rsp_pc_q + STEP : rsp_pc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_ok);
        discard_d     = discard_q - CW'(rsp_ok && (discard_q != '0));
        // Everything still unanswered after this cycle belongs to the old stream.
        if (redirect_valid) begin
            fetch_pc_d = redirect_base;
            rsp_pc_d   = redirect_base;
            discard_d  = outstanding_q - CW'(rsp_ok);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (fifo_push),
        .push_data_i ({rsp_pc_q, imem_rsp_data}),
        .pop_i       (fifo_pop),
        .flush_i     (redirect_valid),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    // A response with nothing outstanding is dropped above; flag it here.
    rsp_without_request: assert property (@(posedge clock) disable iff (reset)
        !(imem_rsp_valid && (outstanding_q == '0)));

endmodule

// File: tb/tb_fetch_prefetch.sv
// Randomised bench for fetch_prefetch with an in-order memory model and a
// stream-level reference (expected PC sequence, credit rule, epochs).
module tb_fetch_prefetch;

    localparam int AB    = 16;
    localparam int DEPTH = 4;
    localparam logic [AB-1:0] RST_PC = 16'h0000;

    logic          clock = 1'b0;
    logic          reset;
    logic          redirect_valid;
    logic [AB-1:0] redirect_pc;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AB-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          inst_valid;
    logic          inst_ready;
    logic [AB-1:0] inst_pc;
    logic [31:0]   inst_data;

    fetch_prefetch #(.ADDRESS_BITS(AB), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AB-1:0] addr;
        int            epoch;
        int            due;
    } req_t;

    req_t          pend[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            last_due = 0;
    int            epoch    = 0;
    int            buffered = 0;
    int            lat_min  = 1;
    int            lat_max  = 1;
    int            n_acc    = 0;
    int            n_pop    = 0;
    bit            prev_rst = 1'b0;
    bit            saw_wrap = 1'b0;
    logic [AB-1:0] exp_pc   = RST_PC;
    logic [AB-1:0] exp_req  = RST_PC;

    function automatic logic [31:0] mem_word(logic [AB-1:0] a);
        return {a, ~a} ^ 32'h5A5A0013;
    endfunction

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Evaluate one cycle against the reference and advance it past the coming edge.
    task automatic model(bit rst, bit redir, logic [AB-1:0] rpc, bit irdy);
        int   outst;
        bit   kept;
        bit   byp;
        bit   exp_iv;
        req_t r;
        kept = 1'b0;
        byp  = 1'b0;
        if (rst) begin
            check_eq("rst_req_valid", imem_req_valid, 0);
            if (prev_rst) begin
                check_eq("rst_inst_valid", inst_valid, 0);
                check_eq("rst_inst_pc", inst_pc, 0);
                check_eq("rst_inst_data", inst_data, 0);
            end
            pend.delete();
            last_due = 0;
            buffered = 0;
            epoch++;
            exp_pc  = RST_PC;
            exp_req = RST_PC;
        end else begin
            outst = pend.size();
            if (imem_rsp_valid) begin
                r    = pend.pop_front();
                kept = (r.epoch == epoch);
            end
            check_eq("req_valid", imem_req_valid, (!redir && (buffered + outst < DEPTH)));
            if (imem_req_valid) check_eq("req_addr", imem_req_addr, exp_req);
`ifdef PREFETCH_BYPASS_EN
            byp = kept && (buffered == 0) && irdy && !redir;
`endif
            exp_iv = (buffered > 0) || byp;
            check_eq("inst_valid", inst_valid, exp_iv);
            if (inst_valid && exp_iv) begin
                check_eq("inst_pc", inst_pc, exp_pc);
                check_eq("inst_data", inst_data, mem_word(exp_pc));
            end
            if (exp_iv && irdy && !redir) begin
                exp_pc = exp_pc + 16'd4;
                n_pop++;
                if (!byp) buffered--;
            end
            if (kept && !redir && !byp) buffered++;
            if (imem_req_valid && imem_req_ready) begin
                r.addr  = imem_req_addr;
                r.epoch = epoch;
                r.due   = cyc + $urandom_range(lat_max, lat_min);
                if (r.due <= last_due) r.due = last_due + 1;
                last_due = r.due;
                pend.push_back(r);
                if (imem_req_addr == 16'h0000 && exp_req == 16'h0000 && epoch > 0 && n_acc > 0) saw_wrap = 1'b1;
                exp_req = exp_req + 16'd4;
                n_acc++;
            end
            if (redir) begin
                epoch++;
                buffered = 0;
                exp_pc   = rpc & 16'hFFFC;
                exp_req  = rpc & 16'hFFFC;
            end
        end
        prev_rst = rst;
    endtask

    task automatic cycle(bit rst, bit redir, logic [AB-1:0] rpc, bit irdy, bit mrdy);
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_ready     = irdy;
        imem_req_ready = mrdy;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clock);
        model(rst, redir, rpc, irdy);
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        int k;
        int base;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        @(posedge clock);
        #1;

        // Latency 1, decode always ready: one instruction per cycle after fill.
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        base = n_pop;
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        check_eq("throughput", n_pop - base, 20);

        // Decode stalled: credit stops issue after DEPTH requests.
        do_reset();
        base = n_acc;
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_eq("stall_accepts", n_acc - base, DEPTH);
        base = n_pop;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        check_eq("stall_drain", n_pop - base >= DEPTH, 1);

        // Latency 3, redirect with three requests in flight.
        lat_min = 3; lat_max = 3;
        do_reset();
        k = 0;
        while (pend.size() != 3 && k < 50) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
            k++;
        end
        check_eq("three_outstanding", pend.size(), 3);
        cycle(1'b0, 1'b1, 16'h0102, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Address wrap from the top of the space.
        lat_min = 1; lat_max = 2;
        n_acc = 0;
        saw_wrap = 1'b0;
        cycle(1'b0, 1'b1, 16'hFFF8, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        check_eq("wrap_seen", saw_wrap, 1);

        // Random traffic: back-pressure, variable latency, redirects, resets.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199, 0) == 0) cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
            else cycle(1'b0, ($urandom_range(99, 0) < 4), 16'($urandom),
                       ($urandom_range(99, 0) < 70), ($urandom_range(99, 0) < 70));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
